// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory loader:
//   - state_t        : loader FSM states (CHK/ERR only reachable when the
//                      IMEM_LOADER_CHECKSUM_EN macro is defined)
//   - BYTES_PER_WORD : stream bytes packed into one instruction word
//   - DEFAULT_DEPTH  : default number of words loaded per session
//   - csum_next()    : running XOR checksum update
// -----------------------------------------------------------------------------
package imem_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_DEPTH  = 32;
  localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    CHK   = 3'd4,
    ERR   = 3'd5
  } state_t;

  // XOR accumulation of one stream byte into the running checksum.
  function automatic logic [7:0] csum_next(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Big-endian byte-to-word packer: each shifted byte enters at the LSB end, so
// after four shifts the first byte sits in word[31:24].
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   clr          : synchronous clear of shift register and byte counter
//   shift_en     : shift data into the register this cycle
//   data [7:0]   : byte to shift in
//   word [31:0]  : current shift-register contents
//   word_full    : the shift happening this cycle completes a word
// -----------------------------------------------------------------------------
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_full
);

  logic [31:0]           shreg_r;
  logic [BYTE_CNT_W-1:0] cnt_r;

  // Shift register and wrapping byte counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_r <= 32'h0000_0000;
      cnt_r   <= '0;
    end else if (clr) begin
      shreg_r <= 32'h0000_0000;
      cnt_r   <= '0;
    end else if (shift_en) begin
      shreg_r <= {shreg_r[23:0], data};
      cnt_r   <= cnt_r + BYTE_CNT_W'(1);
    end else begin
      shreg_r <= shreg_r;
      cnt_r   <= cnt_r;
    end
  end

  assign word      = shreg_r;
  // Counter is at its last slot and a byte is going in: word complete after
  // this edge. The counter wraps to zero on the same edge.
  assign word_full = shift_en && (cnt_r == BYTE_CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Writer side of the instruction memory: packs a valid/ready byte stream into
// 32-bit big-endian words, writes DEPTH words to consecutive addresses from 0,
// and holds the core in reset until the session completes.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// (CHK state) and an error state (ERR) on mismatch; without it err is 0.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   start             : pulse starting a session (IDLE, DONE, ERR only)
//   in_valid/in_ready : byte-stream handshake, in_data MSB-first
//   wr_en/wr_addr/wr_data : one-cycle memory write per packed word
//   cpu_hold          : core reset request (active high)
//   done              : session completed successfully
//   err               : checksum mismatch
// ADDR_W must satisfy 2**ADDR_W >= DEPTH.
// -----------------------------------------------------------------------------
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_t            state_r;
  state_t            state_s;
  logic              clr_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              shift_en_s;
  logic              word_full_s;
  logic [31:0]       word_s;
  logic              last_word_s;
  logic              err_s;
  logic [ADDR_W-1:0] wcnt_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [31:0]       wr_data_r;
  logic              cpu_hold_r;
  logic              done_r;
  logic              err_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_r;
`endif

  // Byte-acceptance window, decoded from the state register only.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      LOAD:    in_ready_s = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:     in_ready_s = 1'b1;
`endif
      default: in_ready_s = 1'b0;
    endcase
  end

  assign accept_s    = in_valid && in_ready_s;
  assign shift_en_s  = accept_s && (state_r == LOAD);
  assign last_word_s = (wcnt_r == ADDR_W'(DEPTH - 1));

  byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr_s),
    .shift_en  (shift_en_s),
    .data      (in_data),
    .word      (word_s),
    .word_full (word_full_s)
  );

  // Next-state logic; clr_s restarts a session from address 0.
  always_comb begin
    state_s = state_r;
    clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        if (word_full_s) begin
          state_s = WRITE;
        end else begin
          state_s = LOAD;
        end
      end
      WRITE: begin
        if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_s = CHK;
`else
          state_s = DONE;
`endif
        end else begin
          state_s = LOAD;
        end
      end
      DONE: begin
        if (start) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = DONE;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_s) begin
          if (in_data == csum_r) begin
            state_s = DONE;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = CHK;
        end
      end
      ERR: begin
        if (start) begin
          state_s = LOAD;
          clr_s   = 1'b1;
        end else begin
          state_s = ERR;
        end
      end
`endif
      default: begin
        state_s = IDLE;
      end
    endcase
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign err_s = (state_s == ERR);
`else
  assign err_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Word counter: address of the word currently being assembled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt_r <= '0;
    end else if (clr_s) begin
      wcnt_r <= '0;
    end else if ((state_r == WRITE) && !last_word_s) begin
      wcnt_r <= wcnt_r + ADDR_W'(1);
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // Write port and status outputs, registered from the next state so they
  // line up with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 32'h0000_0000;
      cpu_hold_r <= 1'b1;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      wr_en_r <= (state_s == WRITE);
      if (state_s == WRITE) begin
        wr_addr_r <= wcnt_r;
      end else begin
        wr_addr_r <= wr_addr_r;
      end
      // Keep the written word once the packer starts refilling.
      if (state_r == WRITE) begin
        wr_data_r <= word_s;
      end else begin
        wr_data_r <= wr_data_r;
      end
      cpu_hold_r <= (state_s != DONE);
      done_r     <= (state_s == DONE);
      err_r      <= err_s;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR of every data byte in the session (checksum byte excluded).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      csum_r <= 8'h00;
    end else if (clr_s) begin
      csum_r <= 8'h00;
    end else if (shift_en_s) begin
      csum_r <= csum_next(csum_r, in_data);
    end else begin
      csum_r <= csum_r;
    end
  end
`endif

  assign in_ready = in_ready_s;
  assign wr_en    = wr_en_r;
  assign wr_addr  = wr_addr_r;
  // During WRITE the packer holds the complete word; afterwards the copy
  // taken on leaving WRITE is presented.
  assign wr_data  = (state_r == WRITE) ? word_s : wr_data_r;
  assign cpu_hold = cpu_hold_r;
  assign done     = done_r;
  assign err      = err_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Self-checking bench for imem_loader: a vector table covers reset and the
// first word cycle by cycle, then hand-written sequences cover full loads,
// stalls, start rules, mid-session reset and (with IMEM_LOADER_CHECKSUM_EN)
// checksum pass/fail.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic        err;

  int n_vec = 0;
  int n_err = 0;

  // write monitor state
  logic mon_en   = 1'b0;
  int   mon_base = 0;
  int   exp_addr = 0;
  int   wr_count = 0;
  logic prev_wr  = 1'b0;
  logic prev_last = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] exp_csum;
  logic       bad_ck;
`endif

  imem_loader #(.DEPTH(32), .ADDR_W(5)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] byte_at(input int i);
    case (i)
      0:       return 8'h08;
      1:       return 8'h02;
      2:       return 8'h00;
      3:       return 8'h05;
      default: return 8'(i * 37 + 11);
    endcase
  endfunction

  function automatic logic [31:0] word_at(input int a);
    return {byte_at(4 * a), byte_at(4 * a + 1), byte_at(4 * a + 2), byte_at(4 * a + 3)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard for the write port, sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_wr && !prev_last) check("ready_after_write", 32'(in_ready), 32'd1);
      if (wr_en) begin
        check("wr_addr", 32'(wr_addr), 32'(exp_addr));
        check("wr_data", wr_data, word_at(exp_addr));
        check("ready_in_write", 32'(in_ready), 32'd0);
        exp_addr++;
        wr_count++;
      end
      prev_wr   = wr_en;
      prev_last = wr_en && (wr_addr == 5'd31);
    end else begin
      prev_wr   = 1'b0;
      prev_last = 1'b0;
      exp_addr  = mon_base;
      wr_count  = mon_base;
    end
  end

  // Feed bytes first..last with random valid gaps; start pulses with byte start_at.
  task automatic send_bytes(input int first, input int last, input int max_gap, input int start_at);
    for (int i = first; i <= last; i++) begin
      int gap;
      bit ok;
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
      end
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = byte_at(i);
        start    = (i == start_at) && (t == 0);
        ok       = in_ready;
        @(posedge clk);
      end
      if (!ok) begin
        n_vec++;
        n_err++;
        $display("FAIL handshake_timeout: byte %0d not accepted within 50 cycles", i);
      end
    end
  endtask

  // Start a session from IDLE/DONE/ERR and check the first LOAD cycle.
  task automatic do_start();
    mon_en   = 1'b0;
    mon_base = 0;
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start  = 1'b0;
    mon_en = 1'b1;
    check("start_hold", 32'(cpu_hold), 32'd1);
    check("start_done", 32'(done), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_ready", 32'(in_ready), 32'd1);
  endtask

  // Called right after the last data byte handshake.
  task automatic finish_session();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
    check("last_write_en", 32'(wr_en), 32'd1);
    check("last_write_hold", 32'(cpu_hold), 32'd1);
    check("last_write_done", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("chk_ready", 32'(in_ready), 32'd1);
    check("chk_hold", 32'(cpu_hold), 32'd1);
    in_valid = 1'b1;
    in_data  = exp_csum ^ {7'd0, bad_ck};
    @(negedge clk);
    in_valid = 1'b0;
    check("end_done", 32'(done), bad_ck ? 32'd0 : 32'd1);
    check("end_hold", 32'(cpu_hold), bad_ck ? 32'd1 : 32'd0);
    check("end_err", 32'(err), bad_ck ? 32'd1 : 32'd0);
`else
    @(negedge clk);
    check("end_done", 32'(done), 32'd1);
    check("end_hold", 32'(cpu_hold), 32'd0);
    check("end_err", 32'(err), 32'd0);
`endif
    check("end_ready", 32'(in_ready), 32'd0);
    check("end_wr_en", 32'(wr_en), 32'd0);
    check("write_count", 32'(wr_count), 32'd32);
  endtask

  typedef struct {
    logic        rst;
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        e_rdy;
    logic        e_wen;
    logic        e_hold;
    logic        e_done;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
  } vec_t;

  vec_t tbl [10];

  initial begin
    // watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
    bad_ck   = 1'b0;
    exp_csum = 8'h00;
    for (int i = 0; i < 128; i++) exp_csum = exp_csum ^ byte_at(i);
`endif

    //             rst   st    vld   dat    rdy   wen   hold  done  addr   data
    tbl[0] = '{1'b0, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h08, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0};
    tbl[8] = '{1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h08020005};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h08020005};

    mon_en   = 1'b0;
    mon_base = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      reset    = tbl[k].rst;
      start    = tbl[k].st;
      in_valid = tbl[k].vld;
      in_data  = tbl[k].dat;
      @(posedge clk);
      #1;
      check($sformatf("v%0d_ready", k), 32'(in_ready), 32'(tbl[k].e_rdy));
      check($sformatf("v%0d_wr_en", k), 32'(wr_en), 32'(tbl[k].e_wen));
      check($sformatf("v%0d_hold", k), 32'(cpu_hold), 32'(tbl[k].e_hold));
      check($sformatf("v%0d_done", k), 32'(done), 32'(tbl[k].e_done));
      check($sformatf("v%0d_err", k), 32'(err), 32'd0);
      check($sformatf("v%0d_addr", k), 32'(wr_addr), 32'(tbl[k].e_addr));
      check($sformatf("v%0d_data", k), wr_data, tbl[k].e_data);
    end

    // Rest of the first session, back to back, with an ignored start at byte 20.
    mon_en = 1'b1;
    send_bytes(4, 127, 0, 20);
    finish_session();

    // Start in DONE (or ERR), then a stalled stream.
    do_start();
    send_bytes(0, 127, 5, -1);
    finish_session();

    // Reset right after word 10 is written.
    do_start();
    send_bytes(0, 43, 2, -1);
    @(negedge clk);
    in_valid = 1'b0;
    check("word10_wr_en", 32'(wr_en), 32'd1);
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(wr_addr), 32'd0);
    check("rst_data", wr_data, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    do_start();
    send_bytes(0, 127, 1, -1);
    finish_session();

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Corrupted checksum byte, then start clears the error.
    bad_ck = 1'b1;
    do_start();
    send_bytes(0, 127, 0, -1);
    finish_session();
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("err_cleared", 32'(err), 32'd0);
    check("err_restart_hold", 32'(cpu_hold), 32'd1);
    check("err_restart_done", 32'(done), 32'd0);
    check("err_restart_ready", 32'(in_ready), 32'd1);
`endif

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface that the single-cycle core reads from.
- Receives a byte stream over a valid/ready handshake and packs each 4 bytes big-endian into one 32-bit instruction word.
- Writes each word into consecutive instruction-memory locations, starting at address 0.
- Holds the core in reset until all DEPTH words are written, then releases it.

Parameters:
DEPTH, 32, number of instruction words loaded per session
ADDR_W, 5, instruction-memory word-address width; must satisfy 2**ADDR_W >= DEPTH

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse that begins a load session
in_valid  input  1  byte-stream data valid
in_ready  output  1  loader accepts a byte this cycle
in_data  input  8  stream byte, most significant byte of each word first
wr_en  output  1  instruction-memory write strobe, one cycle per word
wr_addr  output  ADDR_W  instruction-memory word address
wr_data  output  32  packed instruction word
cpu_hold  output  1  core reset request, active high
done  output  1  high while a session has completed successfully
err  output  1  checksum failure flag

Behaviour:
- Reset asserted (reset=0): state IDLE. Outputs: wr_en=0, wr_addr=0, wr_data=0, in_ready=0, cpu_hold=1, done=0, err=0. Byte count and word count cleared.
- Reset mid-session: the same values apply immediately. Words already written remain in memory. The next start reloads from address 0.
- States: IDLE, LOAD, WRITE, DONE, plus CHK and ERR when the optional feature is compiled in.
- in_ready = (state==LOAD), combinational from the state register. A byte is accepted only when in_valid && in_ready.
- IDLE:
  - start moves to LOAD; cpu_hold stays 1.
  - in_valid is ignored.
- LOAD:
  - Each accepted byte updates the shift register: shreg <= {shreg[23:0], in_data}.
  - The byte counter (2 bits) increments and wraps after the 4th byte.
  - On acceptance of the 4th byte, move to WRITE.
- WRITE (exactly one cycle): wr_en=1, wr_data=packed word, wr_addr=word count. This is registered, so latency is 1 cycle from the 4th byte handshake. in_ready=0.
  - If word count == DEPTH-1, the next state is DONE (or CHK when the feature is compiled in).
  - Otherwise, word count increments and the next state is LOAD.
- wr_en is 0 in every state except WRITE. wr_addr and wr_data hold their last values.
- DONE: cpu_hold=0 and done=1, both from the cycle after the final WRITE.
- start handling:
  - start is ignored in LOAD and WRITE.
  - start in DONE (or ERR): cpu_hold=1, done=0, err=0 next cycle, counters cleared, next state LOAD.
- Gaps in in_valid stall LOAD indefinitely. No timeout.

Optional Feature:
Macro IMEM_LOADER_CHECKSUM_EN.
- With the macro:
  - An 8-bit accumulator XORs every accepted data byte. It is cleared on start and on reset.
  - After the final WRITE, the state moves to CHK. in_ready=1 in CHK, and exactly one checksum byte is accepted.
  - If the checksum byte equals the accumulator, the state moves to DONE.
  - Otherwise, the state moves to ERR: err=1, cpu_hold=1, done=0.
  - ERR exits only on start or reset.
- Without the macro: CHK and ERR do not exist, err is tied to 0, and the final WRITE moves directly to DONE.

Decomposition:
- Shared package imem_loader_pkg contains:
  - The state enum typedef (IDLE, LOAD, WRITE, DONE, CHK, ERR).
  - BYTES_PER_WORD=4.
  - The default DEPTH constant.
- One sub-module, byte_packer. It holds the 32-bit shift register and the 2-bit byte counter, has inputs shift_en and clr, and outputs word and word_full.
- The FSM, word counter, and checksum live in imem_loader.

Test Plan:
- Reset check: hold reset=0 for 3 cycles with in_valid=1 -> in_ready=0, wr_en=0, cpu_hold=1, done=0, err=0 throughout.
- Full load: start, then 128 back-to-back bytes beginning 08 02 00 05 -> first wr_en one cycle after byte 4 with wr_addr=0, wr_data=0x08020005. 32 writes total at addrs 0..31. cpu_hold falls and done rises the cycle after the addr-31 write.
- Stalls: the same 128 bytes with in_valid low for random 0–5 cycle gaps -> identical write sequence. in_ready drops for exactly one cycle after every 4th byte.
- Reset mid-load: assert reset=0 after word 10 is written -> outputs return to reset values at once. A new start plus 128 bytes writes again from addr 0.
- Start rules: a start pulse during LOAD at word 5 -> no effect, addresses continue. A start in DONE -> cpu_hold=1, done=0 next cycle, reload from addr 0.
- IMEM_LOADER_CHECKSUM_EN: 128 bytes plus the correct XOR byte -> done=1, err=0. The same bytes with the checksum byte XOR 0x01 -> err=1, cpu_hold=1, done=0; a following start clears err.
